// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: alu op codes, arbiter FSM states and the illegal-op helper
package alu_arbiter_pkg;

    localparam logic [3:0] OP_AND      = 4'd0;
    localparam logic [3:0] OP_OR       = 4'd1;
    localparam logic [3:0] OP_XOR      = 4'd2;
    localparam logic [3:0] OP_NOR      = 4'd3;
    localparam logic [3:0] OP_ADD      = 4'd5;
    localparam logic [3:0] OP_SUB      = 4'd6;
    localparam logic [3:0] OP_SLT      = 4'd7;
    localparam logic [3:0] OP_SRL      = 4'd8;
    localparam logic [3:0] OP_SLL      = 4'd9;
    localparam logic [3:0] OP_SRA      = 4'd10;
    localparam logic [3:0] MAX_OP_CODE = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Code 4 is a hole in the op map; everything above MAX_OP_CODE is unused.
    function automatic logic op_illegal(input logic [3:0] op);
        return (op == 4'd4) || (op > MAX_OP_CODE);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit alu producing Z plus overflow, equal and zero flags
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [3:0]  op_code,
    output logic [31:0] z,
    output logic        overflow,
    output logic        equal,
    output logic        zero
);

    logic [31:0] sum;
    logic [31:0] dif;

    assign sum = x + y;
    assign dif = x - y;

    // Operation select; unused op codes yield zero; overflow is signed and only for ADD/SUB.
    always_comb begin
        z        = '0;
        overflow = 1'b0;
        case (op_code)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NOR:  z = ~(x | y);
            OP_ADD: begin
                z        = sum;
                overflow = (x[31] == y[31]) && (sum[31] != x[31]);
            end
            OP_SUB: begin
                z        = dif;
                overflow = (x[31] != y[31]) && (dif[31] != x[31]);
            end
            OP_SLT:  z = {31'd0, $signed(x) < $signed(y)};
            OP_SRL:  z = x >> y[4:0];
            OP_SLL:  z = x << y[4:0];
            OP_SRA:  z = $signed(x) >>> y[4:0];
            default: z = '0;
        endcase
    end

    assign equal = (x == y);
    assign zero  = (z == '0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first requester after last_grant wins
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    // Scan from farthest to nearest so the nearest valid requester after last_grant overwrites.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % N_REQ]) begin
                gnt                                     = '0;
                gnt[(int'(last_grant) + k) % N_REQ]     = 1'b1;
                gnt_id                                  = ID_W'((int'(last_grant) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one alu among N_REQ requesters; ALU_ARB_OPCHECK_EN enables illegal-op bypass
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_x,
    input  logic [N_REQ*32-1:0] req_y,
    input  logic [N_REQ*4-1:0]  req_op,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ID_W-1:0]     resp_id,
    output logic [31:0]         resp_z,
    output logic                resp_overflow,
    output logic                resp_equal,
    output logic                resp_zero,
    output logic                resp_err,
    output logic                busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  gnt_id;
    logic [N_REQ-1:0] gnt;
    logic [31:0]      sel_x;
    logic [31:0]      sel_y;
    logic [3:0]       sel_op;
    logic             sel_bad;
    logic [31:0]      x_q;
    logic [31:0]      y_q;
    logic [3:0]       op_q;
    logic [31:0]      alu_z;
    logic             alu_ov;
    logic             alu_eq;
    logic             alu_zero;
    logic             accept;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    alu u_alu (
        .x        (x_q),
        .y        (y_q),
        .op_code  (op_q),
        .z        (alu_z),
        .overflow (alu_ov),
        .equal    (alu_eq),
        .zero     (alu_zero)
    );

    assign sel_x  = req_x[32*gnt_id +: 32];
    assign sel_y  = req_y[32*gnt_id +: 32];
    assign sel_op = req_op[4*gnt_id +: 4];

`ifdef ALU_ARB_OPCHECK_EN
    assign sel_bad = op_illegal(sel_op);
`else
    assign sel_bad = 1'b0;
`endif

    assign req_ready  = (state == IDLE) ? gnt : '0;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // Next state; an illegal op skips EXEC since its response is fixed at accept time.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept    = |req_valid;
                state_nxt = !(|req_valid) ? IDLE : sel_bad ? RESP : EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at grant, result capture in EXEC, round-robin pointer update on response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            op_q          <= '0;
            resp_id       <= '0;
            resp_z        <= '0;
            resp_overflow <= 1'b0;
            resp_equal    <= 1'b0;
            resp_zero     <= 1'b0;
            last_grant    <= ID_W'(N_REQ - 1);
`ifdef ALU_ARB_OPCHECK_EN
            resp_err      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                x_q     <= sel_x;
                y_q     <= sel_y;
                op_q    <= sel_op;
                resp_id <= gnt_id;
            end
`ifdef ALU_ARB_OPCHECK_EN
            if (accept && sel_bad) begin
                resp_z        <= '0;
                resp_overflow <= 1'b0;
                resp_equal    <= 1'b0;
                resp_zero     <= 1'b0;
                resp_err      <= 1'b1;
            end
`endif
            if (state == EXEC) begin
                resp_z        <= alu_z;
                resp_overflow <= alu_ov;
                resp_equal    <= alu_eq;
                resp_zero     <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
                resp_err      <= 1'b0;
`endif
            end
            if (state == RESP && resp_ready) last_grant <= resp_id;
        end
    end

`ifndef ALU_ARB_OPCHECK_EN
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with directed hand-computed vectors
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int ID_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_x = '0;
    logic [N*32-1:0] req_y = '0;
    logic [N*4-1:0]  req_op = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [ID_W-1:0] resp_id;
    logic [31:0]     resp_z;
    logic            resp_overflow;
    logic            resp_equal;
    logic            resp_zero;
    logic            resp_err;
    logic            busy;

    typedef struct {
        int          id;
        logic [31:0] z;
        logic        ov;
        logic        eq;
        logic        zr;
        logic        er;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rise_seen = 0;
    int   w;

    alu_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_op        (req_op),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_z        (resp_z),
        .resp_overflow (resp_overflow),
        .resp_equal    (resp_equal),
        .resp_zero     (resp_zero),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks first-valid latency, then pops and compares on the response handshake.
    always @(negedge clk) begin
        if (rst) rise_seen = 0;
        else if (resp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp id %0d z %h with nothing outstanding", resp_id, resp_z);
            end else begin
                if (!rise_seen) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    rise_seen = 1;
                end
                if (resp_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", 32'(resp_id), e.id);
                    chk("resp_z", resp_z, e.z);
                    chk("resp_overflow", 32'(resp_overflow), 32'(e.ov));
                    chk("resp_equal", 32'(resp_equal), 32'(e.eq));
                    chk("resp_zero", 32'(resp_zero), 32'(e.zr));
                    chk("resp_err", 32'(resp_err), 32'(e.er));
                    rise_seen = 0;
                end
            end
        end
    end

    // Requester i presents one op, waits for its grant, records the expectation, then drops valid.
    task automatic issue(input int i, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                         input logic [31:0] z, input logic ov, input logic eq, input logic zr,
                         input logic er, input int lat, output int waits);
        exp_t e;
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!req_ready[i] && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready[i]) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got no grant for requester %0d required one within 100 cycles", i);
        end else begin
            e = '{id: i, z: z, ov: ov, eq: eq, zr: zr, er: er, lat: lat, acc: cyc};
            sb.push_back(e);
            gnt_log.push_back(i);
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d responses outstanding required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_z", resp_z, 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        @(posedge clk);
        #1;

        issue(0, 32'd1, 32'd2, OP_ADD, 32'd3, 0, 0, 0, 0, 2, w);
        chk("single_ready_same_cycle", w, 0);
        drain();

        do_reset();
        gnt_log.delete();
        fork
            begin
                issue(0, 32'd5, 32'd5, OP_SUB, 32'd0, 0, 1, 1, 0, 2, w);
                issue(0, 32'd5, 32'd5, OP_SUB, 32'd0, 0, 1, 1, 0, 2, w);
            end
            begin
                int w1;
                issue(1, 32'd1, 32'd2, OP_SUB, 32'hffffffff, 0, 0, 0, 0, 2, w1);
                issue(1, 32'd1, 32'd2, OP_SUB, 32'hffffffff, 0, 0, 0, 0, 2, w1);
            end
        join
        drain();
        chk("rr_count", gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) chk("rr_order", gnt_log[k], k % 2);

        gnt_log.delete();
        resp_ready = 1'b0;
        fork
            issue(0, 32'hf0f0f0f0, 32'h0ff00ff0, OP_XOR, 32'hff00ff00, 0, 0, 0, 0, 2, w);
            begin
                int w1;
                @(posedge clk);
                #1;
                issue(1, 32'hffff0000, 32'h12345678, OP_AND, 32'h12340000, 0, 0, 0, 0, 2, w1);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 50 && !resp_valid; k++) @(negedge clk);
                chk("bp_resp_seen", 32'(resp_valid), 1);
                repeat (5) begin
                    chk("bp_resp_valid", 32'(resp_valid), 1);
                    chk("bp_resp_z", resp_z, 32'hff00ff00);
                    chk("bp_resp_id", 32'(resp_id), 0);
                    chk("bp_req_ready", 32'(req_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 resp_ready = 1'b1;
            end
        join
        drain();
        chk("bp_next_grant_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) chk("bp_next_grant", gnt_log[1], 1);

        issue(0, 32'h7fffffff, 32'd1, OP_ADD, 32'h80000000, 1, 0, 0, 0, 2, w);
        drain();

        req_x[63:32] = 32'h80000000;
        req_y[63:32] = 32'd4;
        req_op[7:4]  = OP_SRA;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(req_ready), 32'b10);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_exec", 32'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 0);
        chk("mid_rst_resp_z", resp_z, 0);
        @(posedge clk);
        #1;
        gnt_log.delete();
        req_valid[1] = 1'b1;
        issue(0, 32'd1, 32'd4, OP_SLL, 32'd16, 0, 0, 0, 0, 2, w);
        chk("post_rst_grant_wait", w, 0);
        chk("post_rst_grant_id", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        issue(1, 32'h80000000, 32'd4, OP_SRA, 32'hf8000000, 0, 0, 0, 0, 2, w);
        drain();

`ifdef ALU_ARB_OPCHECK_EN
        issue(0, 32'd3, 32'd4, 4'd12, 32'd0, 0, 0, 0, 1, 1, w);
`else
        issue(0, 32'd3, 32'd4, 4'd12, 32'd0, 0, 0, 1, 0, 2, w);
`endif
        drain();
        issue(1, 32'd5, 32'd9, OP_SLT, 32'd1, 0, 0, 0, 0, 2, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
